// File: rtl/ct_vfdsu_wb_buf_if.sv
// Result hand-off bundle between the VFDSU EX4 stage, the buffer and the VFPU write-back arbiter.
// master drives push/grant/flush; slave (the buffer) drives head and status.
interface ct_vfdsu_wb_buf_if #(
  parameter int DATA_W = 64,
  parameter int PREG_W = 7
);
  logic              rtu_yy_xx_flush;
  logic              vfdsu_wb_req;
  logic [DATA_W-1:0] vfdsu_wb_data;
  logic [4:0]        vfdsu_wb_fflags;
  logic [PREG_W-1:0] vfdsu_wb_preg;
  logic              vfpu_wb_grant;
  logic              wb_vfpu_vld;
  logic [DATA_W-1:0] wb_vfpu_data;
  logic [4:0]        wb_vfpu_fflags;
  logic [PREG_W-1:0] wb_vfpu_preg;
  logic              wb_vfpu_urgent;
  logic              wb_vfdsu_full;
  logic              wb_vfdsu_empty;
  logic              wb_vfdsu_ovfl;

  modport master (
    output rtu_yy_xx_flush, vfdsu_wb_req, vfdsu_wb_data, vfdsu_wb_fflags,
           vfdsu_wb_preg, vfpu_wb_grant,
    input  wb_vfpu_vld, wb_vfpu_data, wb_vfpu_fflags, wb_vfpu_preg,
           wb_vfpu_urgent, wb_vfdsu_full, wb_vfdsu_empty, wb_vfdsu_ovfl
  );

  modport slave (
    input  rtu_yy_xx_flush, vfdsu_wb_req, vfdsu_wb_data, vfdsu_wb_fflags,
           vfdsu_wb_preg, vfpu_wb_grant,
    output wb_vfpu_vld, wb_vfpu_data, wb_vfpu_fflags, wb_vfpu_preg,
           wb_vfpu_urgent, wb_vfdsu_full, wb_vfdsu_empty, wb_vfdsu_ovfl
  );
endinterface

// File: rtl/ct_vfdsu_wb_buf.sv
// In-order fdiv/fsqrt result FIFO feeding the VFPU write-back arbiter; push-to-vld 1 cycle, no bypass.
// Full stalls divide issue; a push while full is dropped and latches ovfl. Optional starvation flag: VFDSU_WB_URGENT_EN.
module ct_vfdsu_wb_buf #(
  parameter int DEPTH         = 2,
  parameter int DATA_W        = 64,
  parameter int PREG_W        = 7,
  parameter int URGENT_THRESH = 8
) (
  input logic               forever_cpuclk,
  input logic               cpurst_b,
  ct_vfdsu_wb_buf_if.slave  wb
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [4:0]        fflags;
    logic [PREG_W-1:0] preg;
  } entry_t;

  entry_t           entry [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic   flush;
  logic   vld;
  logic   full;
  logic   pop;
  logic   push;
  entry_t wr_entry;
  entry_t head;

  assign flush = wb.rtu_yy_xx_flush;
  assign vld   = (count != '0);
  assign full  = (count == CNT_W'(DEPTH));

  // Flush wins over everything in its cycle, so neither side may move state.
  assign pop  = wb.vfpu_wb_grant && vld && !flush;
  assign push = wb.vfdsu_wb_req && (!full || pop) && !flush;

  assign wr_entry = '{data:   wb.vfdsu_wb_data,
                      fflags: wb.vfdsu_wb_fflags,
                      preg:   wb.vfdsu_wb_preg};

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= '0;
      end
    end else if (push) begin
      entry[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      wb.wb_vfdsu_ovfl <= 1'b0;
    end else if (flush) begin
      wb.wb_vfdsu_ovfl <= 1'b0;
    end else if (wb.vfdsu_wb_req && full && !pop) begin
      wb.wb_vfdsu_ovfl <= 1'b1;
    end
  end

  // Stale storage behind the read pointer must not leak onto the bus when empty.
  assign head = vld ? entry[rd_ptr] : '0;

  assign wb.wb_vfpu_vld    = vld;
  assign wb.wb_vfpu_data   = head.data;
  assign wb.wb_vfpu_fflags = head.fflags;
  assign wb.wb_vfpu_preg   = head.preg;
  assign wb.wb_vfdsu_full  = full;
  assign wb.wb_vfdsu_empty = !vld;

`ifdef VFDSU_WB_URGENT_EN
  localparam int WC_W = $clog2(URGENT_THRESH + 1);

  logic [WC_W-1:0] wait_cnt;

  // Saturates at the threshold; that is all the urgency decode ever needs.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      wait_cnt <= '0;
    end else if (flush || pop || !vld) begin
      wait_cnt <= '0;
    end else if (wait_cnt < WC_W'(URGENT_THRESH)) begin
      wait_cnt <= wait_cnt + WC_W'(1);
    end
  end

  assign wb.wb_vfpu_urgent = vld && (wait_cnt >= WC_W'(URGENT_THRESH));
`else
  // Threshold is only meaningful when starvation tracking is built in.
  assign wb.wb_vfpu_urgent = 1'b0 & (URGENT_THRESH > 0);
`endif

endmodule

// File: tb/tb_ct_vfdsu_wb_buf.sv
// Directed bench for ct_vfdsu_wb_buf: FIFO order, full/overflow, simultaneous push+pop wrap,
// flush priority, urgency flag and asynchronous reset.
module tb_ct_vfdsu_wb_buf;

  logic clk;
  logic rst_b;
  int   total;
  int   passed;

  ct_vfdsu_wb_buf_if #(.DATA_W(64), .PREG_W(7)) wb_if ();

  ct_vfdsu_wb_buf #(
    .DEPTH(2), .DATA_W(64), .PREG_W(7), .URGENT_THRESH(8)
  ) dut (
    .forever_cpuclk(clk),
    .cpurst_b      (rst_b),
    .wb            (wb_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one edge; inputs and checks happen 1ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] dat_of(input logic [6:0] p);
    return 64'hA5A5_0000_0000_0000 | {57'h0, p};
  endfunction

  task automatic step(input logic req, input logic [6:0] p, input logic grant, input logic flush);
    wb_if.vfdsu_wb_req    = req;
    wb_if.vfdsu_wb_data   = dat_of(p);
    wb_if.vfdsu_wb_fflags = p[4:0];
    wb_if.vfdsu_wb_preg   = p;
    wb_if.vfpu_wb_grant   = grant;
    wb_if.rtu_yy_xx_flush = flush;
    cyc();
    wb_if.vfdsu_wb_req    = 1'b0;
    wb_if.vfpu_wb_grant   = 1'b0;
    wb_if.rtu_yy_xx_flush = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [6:0] p);
    chk({tag, "_vld"},  64'(wb_if.wb_vfpu_vld), 64'd1);
    chk({tag, "_preg"}, 64'(wb_if.wb_vfpu_preg), 64'(p));
    chk({tag, "_data"}, wb_if.wb_vfpu_data, dat_of(p));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vld"},    64'(wb_if.wb_vfpu_vld), 64'd0);
    chk({tag, "_data"},   wb_if.wb_vfpu_data, 64'd0);
    chk({tag, "_fflags"}, 64'(wb_if.wb_vfpu_fflags), 64'd0);
    chk({tag, "_preg"},   64'(wb_if.wb_vfpu_preg), 64'd0);
    chk({tag, "_urgent"}, 64'(wb_if.wb_vfpu_urgent), 64'd0);
    chk({tag, "_full"},   64'(wb_if.wb_vfdsu_full), 64'd0);
    chk({tag, "_empty"},  64'(wb_if.wb_vfdsu_empty), 64'd1);
  endtask

  initial begin
    logic [6:0] exp_head [4];
    logic       exp_urg;
    total  = 0;
    passed = 0;
    rst_b  = 1'b0;
    wb_if.rtu_yy_xx_flush = 1'b0;
    wb_if.vfdsu_wb_req    = 1'b0;
    wb_if.vfdsu_wb_data   = '0;
    wb_if.vfdsu_wb_fflags = '0;
    wb_if.vfdsu_wb_preg   = '0;
    wb_if.vfpu_wb_grant   = 1'b0;
    repeat (3) cyc();
    rst_b = 1'b1;
    cyc();
    chk_idle("reset");
    chk("reset_ovfl", 64'(wb_if.wb_vfdsu_ovfl), 64'd0);

    // Single result with exact fields, held without grant, then retired.
    wb_if.vfdsu_wb_req    = 1'b1;
    wb_if.vfdsu_wb_data   = 64'h3FF0_0000_0000_0000;
    wb_if.vfdsu_wb_fflags = 5'b00001;
    wb_if.vfdsu_wb_preg   = 7'd12;
    cyc();
    wb_if.vfdsu_wb_req = 1'b0;
    chk("single_vld",    64'(wb_if.wb_vfpu_vld), 64'd1);
    chk("single_data",   wb_if.wb_vfpu_data, 64'h3FF0_0000_0000_0000);
    chk("single_fflags", 64'(wb_if.wb_vfpu_fflags), 64'b00001);
    chk("single_preg",   64'(wb_if.wb_vfpu_preg), 64'd12);
    chk("single_empty",  64'(wb_if.wb_vfdsu_empty), 64'd0);
    chk("single_full",   64'(wb_if.wb_vfdsu_full), 64'd0);
    cyc();
    chk("hold_data", wb_if.wb_vfpu_data, 64'h3FF0_0000_0000_0000);
    chk("hold_preg", 64'(wb_if.wb_vfpu_preg), 64'd12);
    step(1'b0, 7'd0, 1'b1, 1'b0);
    chk_idle("single_pop");

    // A grant with nothing valid must not disturb the empty state.
    step(1'b0, 7'd0, 1'b1, 1'b0);
    chk_idle("idle_grant");

    // Fill, overflow, then drain in order.
    step(1'b1, 7'd3, 1'b0, 1'b0);
    chk("fill1_full", 64'(wb_if.wb_vfdsu_full), 64'd0);
    chk_head("fill1", 7'd3);
    step(1'b1, 7'd4, 1'b0, 1'b0);
    chk("fill2_full", 64'(wb_if.wb_vfdsu_full), 64'd1);
    chk("fill2_ovfl", 64'(wb_if.wb_vfdsu_ovfl), 64'd0);
    step(1'b1, 7'd5, 1'b0, 1'b0);
    chk("drop_ovfl", 64'(wb_if.wb_vfdsu_ovfl), 64'd1);
    chk("drop_full", 64'(wb_if.wb_vfdsu_full), 64'd1);
    chk_head("drop", 7'd3);
    step(1'b0, 7'd0, 1'b1, 1'b0);
    chk_head("drain1", 7'd4);
    chk("drain1_full", 64'(wb_if.wb_vfdsu_full), 64'd0);
    step(1'b0, 7'd0, 1'b1, 1'b0);
    chk("drain2_empty", 64'(wb_if.wb_vfdsu_empty), 64'd1);
    chk("drain2_vld",   64'(wb_if.wb_vfpu_vld), 64'd0);
    chk("ovfl_sticky",  64'(wb_if.wb_vfdsu_ovfl), 64'd1);

    // Push and pop together while full, four times to wrap both pointers.
    step(1'b1, 7'd3, 1'b0, 1'b0);
    step(1'b1, 7'd4, 1'b0, 1'b0);
    exp_head[0] = 7'd4;
    exp_head[1] = 7'd9;
    exp_head[2] = 7'd10;
    exp_head[3] = 7'd11;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 7'(9 + i), 1'b1, 1'b0);
      chk_head($sformatf("pp%0d", i), exp_head[i]);
      chk($sformatf("pp%0d_full", i), 64'(wb_if.wb_vfdsu_full), 64'd1);
    end
    step(1'b0, 7'd0, 1'b1, 1'b0);
    chk_head("pp_drain", 7'd12);
    chk("pp_drain_full", 64'(wb_if.wb_vfdsu_full), 64'd0);
    step(1'b0, 7'd0, 1'b1, 1'b0);
    chk("pp_empty", 64'(wb_if.wb_vfdsu_empty), 64'd1);

    // Flush with a simultaneous push while full and overflowed.
    step(1'b1, 7'd20, 1'b0, 1'b0);
    step(1'b1, 7'd21, 1'b0, 1'b0);
    step(1'b1, 7'd22, 1'b0, 1'b0);
    chk("pre_flush_ovfl", 64'(wb_if.wb_vfdsu_ovfl), 64'd1);
    chk("pre_flush_full", 64'(wb_if.wb_vfdsu_full), 64'd1);
    step(1'b1, 7'd23, 1'b1, 1'b1);
    chk_idle("flush");
    chk("flush_ovfl", 64'(wb_if.wb_vfdsu_ovfl), 64'd0);
    cyc();
    chk("flush_after_empty", 64'(wb_if.wb_vfdsu_empty), 64'd1);

    // Urgency: flag rises once the head has waited THRESH cycles.
    step(1'b1, 7'd30, 1'b0, 1'b0);
    for (int k = 0; k < 11; k++) begin
`ifdef VFDSU_WB_URGENT_EN
      exp_urg = (k >= 8);
`else
      exp_urg = 1'b0;
`endif
      chk($sformatf("urgent_w%0d", k), 64'(wb_if.wb_vfpu_urgent), 64'(exp_urg));
      cyc();
    end
    chk_head("urgent_hold", 7'd30);
    step(1'b0, 7'd0, 1'b1, 1'b0);
    chk("urgent_after_pop", 64'(wb_if.wb_vfpu_urgent), 64'd0);
    chk("urgent_pop_empty", 64'(wb_if.wb_vfdsu_empty), 64'd1);

    // Asynchronous reset with one entry held and ovfl set.
    step(1'b1, 7'd40, 1'b0, 1'b0);
    step(1'b1, 7'd41, 1'b0, 1'b0);
    step(1'b1, 7'd42, 1'b0, 1'b0);
    step(1'b0, 7'd0, 1'b1, 1'b0);
    chk_head("pre_rst", 7'd41);
    chk("pre_rst_ovfl", 64'(wb_if.wb_vfdsu_ovfl), 64'd1);
    #2;
    rst_b = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_ovfl", 64'(wb_if.wb_vfdsu_ovfl), 64'd0);
    cyc();
    rst_b = 1'b1;
    cyc();
    chk_idle("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
